ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 keyboard receive stage on the 100 MHz board clock. It synchronizes and deglitches the raw PS2_CLK/PS2_DATA pins and deframes 11-bit device-to-host frames. It checks start, odd-parity and stop bits, and shifts each good scancode byte into a 32-bit history register. That register is the 8-hex-digit value handed downstream to the seven-segment display driver.

Parameters:
FILTER_CYCLES, 8, consecutive clk_100mhz cycles a synchronized kbd_clk level must hold before the filtered clock changes (range 1..255)
TIMEOUT_CYCLES, 200000, clk_100mhz cycles without a filtered falling edge, while mid-frame, before the frame is aborted (2 ms at 100 MHz)

Ports:
clk_100mhz  input   1   system clock, 100 MHz
nrst        input   1   asynchronous active-low reset; clears all state
kbd_clk     input   1   raw PS/2 clock pin, asynchronous to clk_100mhz
kbd_data    input   1   raw PS/2 data pin, asynchronous to clk_100mhz
keycodes    output  32  last four good bytes; [7:0] is the newest, [31:24] the oldest
code_valid  output  1   one-cycle pulse when a good byte has been shifted into keycodes
frame_err   output  1   one-cycle pulse on a parity, start or stop error, or a timeout abort

Behaviour:
- Clock and reset: one clock, clk_100mhz; reset nrst is asynchronous, active-low.
- Reset values:
  - keycodes = 32'h0, code_valid = 0, frame_err = 0.
  - FSM = IDLE; bit counter, shift register and timeout counter = 0.
  - Synchronizer flops and filtered clock = 1 (bus-idle level).
- Synchronization: each of kbd_clk and kbd_data passes through a 2-flop synchronizer.
- Clock filter:
  - A counter increments while the synced kbd_clk differs from the filtered clock, and clears when they match.
  - When the counter reaches FILTER_CYCLES, the filtered clock takes the synced value and the counter clears.
  - A filtered 1->0 transition produces fall_edge for one cycle.
  - Data is sampled from synced kbd_data in the fall_edge cycle.
- FSM, advancing only on fall_edge except for the timeout:
  - IDLE: if data=0 (start bit), go to DATA with bit_cnt=0. If data=1, stay in IDLE; this is not an error.
  - DATA: shift data in LSB-first; after the 8th bit (bit_cnt=7), go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: evaluate the frame and go to IDLE.
    - Good frame = stop bit 1 AND (XOR of 8 data bits XOR parity bit) = 1.
    - Good: keycodes <= {keycodes[23:0], byte}; code_valid=1 on the next cycle.
    - Bad: keycodes unchanged; frame_err=1 on the next cycle.
- Latency: code_valid/frame_err rise exactly 1 clk_100mhz cycle after the STOP-bit fall_edge cycle. Counted from the raw pin, total latency is 2 sync cycles + FILTER_CYCLES + 1 cycle.
- Timeout:
  - The counter clears on every fall_edge and in IDLE; it increments in DATA, PARITY and STOP.
  - On reaching TIMEOUT_CYCLES: go to IDLE, frame_err pulses 1 cycle, keycodes unchanged, partial byte discarded.
  - If fall_edge and timeout expiry coincide, the edge wins: it is processed normally and the counter clears.
- code_valid and frame_err are never high in the same cycle. Each is registered and high for exactly 1 cycle per event.
- keycodes changes only on a good frame; shifting discards the oldest byte, with no wrap-around back-fill.
- Reset mid-frame: immediate return to reset values. The next frame is accepted only after a fresh start bit following reset deassertion; a remainder of an interrupted frame may produce frame_err and is never written to keycodes.
- The host never drives the PS/2 lines; the block is receive-only.

Test Plan:
- Reset -> keycodes=32'h00000000, code_valid=0, frame_err=0. Then send frame byte 8'h1C, parity 0, stop 1 at a 12.5 kHz bit rate -> code_valid single pulse, keycodes=32'h0000001C.
- Send bytes 8'hF0 (parity 1), then 8'h1C (parity 0) after the first test -> two code_valid pulses, final keycodes=32'h001CF01C. Then send 8'h12 and 8'h59 -> keycodes=32'hF01C1259; the original 8'h1C has been shifted out.
- Send 8'h1C with parity 1 (bad) -> frame_err pulse, no code_valid, keycodes unchanged. Send 8'h1C with stop 0 -> frame_err, unchanged.
- With TIMEOUT_CYCLES=1000: send start bit + 3 data bits, then hold the clock high -> frame_err exactly 1000 cycles after the last fall_edge, FSM back in IDLE. A following full 8'h29 frame -> keycodes[7:0]=8'h29.
- Glitch: pulse kbd_clk low for FILTER_CYCLES-2 cycles in IDLE and mid-frame -> no bit sampled, no pulses. The subsequent valid 8'h1C frame is still decoded correctly.
- Assert nrst low after 5 bits of a frame -> all outputs at reset values immediately. After release, a complete 8'h5A frame -> keycodes=32'h0000005A, code_valid once.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw pins, deframes
// 11-bit device-to-host frames and keeps the last four good scancodes.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_100mhz,
  input  logic        nrst,
  input  logic        kbd_clk,
  input  logic        kbd_data,
  output logic [31:0] keycodes,
  output logic        code_valid,
  output logic        frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      FiltLast = 8'(FILTER_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  logic            clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic [7:0]      filt_cnt_q, filt_cnt_d;
  logic            filt_clk_q, filt_clk_d;
  logic            fall_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_expired;
  logic [31:0]     keycodes_q, keycodes_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= kbd_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= kbd_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Clock filter: the synced level must differ for FILTER_CYCLES in a row.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FiltLast) begin
        filt_clk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  // Filter state and registered falling-edge strobe.
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_clk_q <= filt_clk_d;
      fall_q     <= filt_clk_q & ~filt_clk_d;
    end
  end

  assign tmo_expired = (tmo_q == TmoLast);

  // FSM state register.
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a falling edge takes priority over timeout expiry.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = (fall_q || state_q == StIdle) ? '0 : tmo_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (fall_q && !data_sync_q) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall_q) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end else if (tmo_expired) begin
          state_d = StIdle;
          tmo_d   = '0;
        end
      end
      StParity: begin
        if (fall_q) begin
          par_d   = data_sync_q;
          state_d = StStop;
        end else if (tmo_expired) begin
          state_d = StIdle;
          tmo_d   = '0;
        end
      end
      StStop: begin
        if (fall_q) begin
          state_d = StIdle;
        end else if (tmo_expired) begin
          state_d = StIdle;
          tmo_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: frame verdict on the stop edge, or abort on timeout.
  always_comb begin
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    keycodes_d   = keycodes_q;
    if (state_q == StStop && fall_q) begin
      if (data_sync_q && (^shift_q ^ par_q)) begin
        code_valid_d = 1'b1;
        keycodes_d   = {keycodes_q[23:0], shift_q};
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (state_q != StIdle && !fall_q && tmo_expired) begin
      frame_err_d = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      keycodes_q   <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      keycodes_q   <= keycodes_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keycodes   = keycodes_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx. The PS/2 bit period is compressed to
// about 100 system clocks so the run stays short; the 1000-cycle timeout is
// still far longer than any clock phase.
module tb_ps2_kbd_rx;

  localparam int unsigned F   = 8;
  localparam int unsigned T   = 1000;
  // Raw clock pin fall to output pulse: 2 sync + filter + 1 cycle.
  localparam int unsigned LAT = F + 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        kbd_clk;
  logic        kbd_data;
  logic [31:0] keycodes;
  logic        code_valid;
  logic        frame_err;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FILTER_CYCLES  (F),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_100mhz (clk),
    .nrst       (nrst),
    .kbd_clk    (kbd_clk),
    .kbd_data   (kbd_data),
    .keycodes   (keycodes),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit              err;
    logic [31:0]     kc;
    int unsigned     cyc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc      = 0;
  int unsigned n_cmp    = 0;
  int unsigned n_bad    = 0;
  int unsigned n_valid  = 0;
  int unsigned n_err    = 0;
  int unsigned last_fall = 0;
  int unsigned half     = 50;
  logic [31:0] m_kc     = '0;   // model: keycodes after all frames sent so far
  logic [31:0] shown_kc = '0;   // model: keycodes the DUT should show right now
  bit          nxt_err;
  logic [31:0] nxt_kc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of the DUT against the event queue.
  task automatic compare_cycle();
    ev_t e;
    check32("exclusive pulses", {31'b0, code_valid & frame_err}, 32'h0);
    if (code_valid) n_valid++;
    if (frame_err) n_err++;
    if (code_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        check32("unexpected pulse", {30'b0, code_valid, frame_err}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check32("pulse kind", {30'b0, code_valid, frame_err}, e.err ? 32'h1 : 32'h2);
        check32("pulse cycle", 32'(cyc), 32'(e.cyc));
        shown_kc = e.kc;
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      e = exp_q.pop_front();
      check32("missing pulse", {30'b0, code_valid, frame_err}, e.err ? 32'h1 : 32'h2);
      shown_kc = e.kc;
    end
    check32("keycodes", keycodes, shown_kc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    compare_cycle();
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  function automatic bit odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // One bit cell: data set while the clock is high, then a low half period.
  task automatic drive_bit(input bit b, input bit push_ev, input bit glit);
    kbd_data = b;
    if (glit) begin
      idle(10);
      kbd_clk = 1'b0;
      idle(F - 2);
      kbd_clk = 1'b1;
      idle(half - 10 - (F - 2));
    end else begin
      idle(half);
    end
    kbd_clk   = 1'b0;
    last_fall = cyc;
    if (push_ev) begin
      exp_q.push_back('{err: nxt_err, kc: nxt_kc, cyc: cyc + LAT});
      m_kc = nxt_kc;
    end
    idle(half);
    kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int glit_bit);
    logic [10:0] f;
    f       = {stop, par, b, 1'b0};
    nxt_err = !(stop && ((^b ^ par) == 1'b1));
    nxt_kc  = nxt_err ? m_kc : {m_kc[23:0], b};
    for (int i = 0; i < 11; i++) drive_bit(f[i], i == 10, i == glit_bit);
    kbd_data = 1'b1;
    idle(30);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, -1);
  endtask

  task automatic glitch_idle();
    kbd_clk = 1'b0;
    idle(F - 2);
    kbd_clk = 1'b1;
    idle(30);
  endtask

  int unsigned v0, e0, r;
  logic [7:0]  rb;

  initial begin
    nrst     = 1'b0;
    kbd_clk  = 1'b1;
    kbd_data = 1'b1;
    idle(3);
    check32("reset keycodes", keycodes, 32'h0);
    check32("reset code_valid", {31'b0, code_valid}, 32'h0);
    check32("reset frame_err", {31'b0, frame_err}, 32'h0);
    nrst = 1'b1;
    idle(20);

    // Single good frame.
    v0 = n_valid;
    send_good(8'h1C);
    check32("first frame keycodes", keycodes, 32'h0000001C);
    check32("first frame pulses", 32'(n_valid - v0), 32'd1);

    // History shifting.
    v0 = n_valid;
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check32("two frames keycodes", keycodes, 32'h001CF01C);
    check32("two frames pulses", 32'(n_valid - v0), 32'd2);
    send_good(8'h12);
    send_good(8'h59);
    check32("shift-out keycodes", keycodes, 32'hF01C1259);

    // Bad parity and bad stop.
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    check32("bad frames keycodes", keycodes, 32'hF01C1259);
    check32("bad frames errs", 32'(n_err - e0), 32'd2);
    check32("bad frames valids", 32'(n_valid - v0), 32'd0);

    // Timeout: start + 3 data bits, then the clock stays high.
    e0 = n_err;
    half = 50;
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{err: 1'b1, kc: m_kc, cyc: last_fall + LAT + T});
    kbd_data = 1'b1;
    idle(T + LAT + 20);
    check32("timeout errs", 32'(n_err - e0), 32'd1);
    send_good(8'h29);
    check32("after timeout low byte", {24'h0, keycodes[7:0]}, 32'h29);

    // Glitches in idle and mid-frame.
    v0 = n_valid;
    e0 = n_err;
    glitch_idle();
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    check32("glitch keycodes", keycodes, 32'h1259291C);
    check32("glitch pulses", 32'(n_valid - v0) + 32'(n_err - e0), 32'd1);

    // Reset after 5 bits of a frame.
    for (int i = 0; i < 5; i++) drive_bit(i == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    check32("mid-frame reset keycodes", keycodes, 32'h0);
    check32("mid-frame reset pulses", {30'b0, code_valid, frame_err}, 32'h0);
    exp_q.delete();
    m_kc     = '0;
    shown_kc = '0;
    idle(5);
    nrst = 1'b1;
    idle(20);
    v0 = n_valid;
    send_good(8'h5A);
    check32("post-reset keycodes", keycodes, 32'h0000005A);
    check32("post-reset pulses", 32'(n_valid - v0), 32'd1);

    // Randomized frames: mostly good, some bad parity/stop, some glitches.
    for (int k = 0; k < 24; k++) begin
      half = $urandom_range(40, 60);
      rb   = 8'($urandom);
      r    = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) glitch_idle();
      send_frame(rb, odd_par(rb) ^ (r == 7), r != 8, (r == 9) ? int'($urandom_range(0, 10)) : -1);
      idle($urandom_range(0, 40));
    end

    idle(100);
    check32("final keycodes", keycodes, m_kc);
    check32("pending events", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
